// File: rtl/serial_word_collector_pkg.sv
// Shared types and helpers for the serial word collector.
package serial_pkg;

    typedef enum logic {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } collector_state_t;

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_word_collector_word_out_buffer.sv
// One-entry valid/ready output register; a completed word arriving while the
// entry is still held (and not being consumed) is dropped and flagged as overrun.
module word_out_buffer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_word,
    input  logic         word_ready,
    input  logic         clear_err,
    output logic         word_valid,
    output logic [N-1:0] word_out,
    output logic         overrun
);

    logic consume;
    logic accept;
    logic drop;

    always_comb begin
        consume = word_valid && word_ready;
        accept  = load && (!word_valid || word_ready);
        drop    = load && word_valid && !word_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_valid <= 1'b0;
            word_out   <= '0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                word_valid <= 1'b1;
                word_out   <= load_word;
            end else if (consume) begin
                word_valid <= 1'b0;
            end

            // Set has priority over clear when both happen in one cycle.
            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles an LSB-first serial bit stream into N-bit words, aligned by
// frame_start, and presents them through a one-entry valid/ready buffer.
module serial_word_collector
    import serial_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    input  logic                  frame_start,
    input  logic                  word_ready,
    input  logic                  clear_err,
    output logic                  word_valid,
    output logic [N-1:0]          word_out,
    output logic [cnt_w(N)-1:0]   bit_count,
    output logic                  overrun,
    output logic                  sync_err,
    output logic                  hunting
);

    localparam int unsigned CW = cnt_w(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
    localparam logic [CW-1:0] ONE_BIT  = CW'(1);

    collector_state_t state;
    logic [N-1:0]     shreg;
    logic [N-1:0]     next_word;
    logic [N-1:0]     first_bit_word;
    logic             resync;
    logic             complete;

    always_comb begin
        next_word      = {bit_in, shreg[N-1:1]};
        first_bit_word = {bit_in, {(N-1){1'b0}}};
        resync         = (state == COLLECT) && bit_valid && frame_start && (bit_count != '0);
        complete       = (state == COLLECT) && bit_valid && !resync && (bit_count == LAST_BIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            shreg     <= '0;
            bit_count <= '0;
            hunting   <= 1'b1;
            sync_err  <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (bit_valid && frame_start) begin
                        shreg     <= first_bit_word;
                        bit_count <= ONE_BIT;
                        state     <= COLLECT;
                        hunting   <= 1'b0;
                    end
                end
                COLLECT: begin
                    // A misplaced frame_start restarts the word with this bit as bit 0.
                    if (resync) begin
                        shreg     <= first_bit_word;
                        bit_count <= ONE_BIT;
                    end else if (bit_valid) begin
                        shreg     <= next_word;
                        bit_count <= complete ? '0 : bit_count + ONE_BIT;
                    end
                end
                default: begin
                    state   <= HUNT;
                    hunting <= 1'b1;
                end
            endcase

            if (resync) begin
                sync_err <= 1'b1;
            end else if (clear_err) begin
                sync_err <= 1'b0;
            end
        end
    end

    word_out_buffer #(
        .N(N)
    ) u_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (complete),
        .load_word  (next_word),
        .word_ready (word_ready),
        .clear_err  (clear_err),
        .word_valid (word_valid),
        .word_out   (word_out),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_serial_word_collector.sv
// Scoreboard bench: expected words are queued at stimulus time and popped by a
// negedge monitor whenever the collector hands a word over (valid & ready).
module tb_serial_word_collector;

    localparam int unsigned N = 8;

    logic         clk;
    logic         reset;
    logic         bit_valid;
    logic         bit_in;
    logic         frame_start;
    logic         word_ready;
    logic         clear_err;
    logic         word_valid;
    logic [N-1:0] word_out;
    logic [2:0]   bit_count;
    logic         overrun;
    logic         sync_err;
    logic         hunting;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] exp_q[$];

    serial_word_collector #(
        .N(N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .frame_start (frame_start),
        .word_ready  (word_ready),
        .clear_err   (clear_err),
        .word_valid  (word_valid),
        .word_out    (word_out),
        .bit_count   (bit_count),
        .overrun     (overrun),
        .sync_err    (sync_err),
        .hunting     (hunting)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are applied at posedge+1; one step crosses exactly one active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        bit_valid   = 1'b1;
        bit_in      = b;
        frame_start = fs;
        step();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
        bit_in      = 1'b0;
    endtask

    task automatic send_word(input logic [N-1:0] w, input logic fs_first);
        for (int i = 0; i < int'(N); i++) begin
            send_bit(w[i], fs_first && (i == 0));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got 0x%0h expected no word", word_out);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (word_out !== e) begin
                    failures++;
                    $display("FAIL sb_word: got 0x%0h expected 0x%0h", word_out, e);
                end
            end
        end
    end

    initial begin
        logic [N-1:0] w;
        reset       = 1'b1;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        frame_start = 1'b0;
        word_ready  = 1'b0;
        clear_err   = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_out",   32'(word_out),   32'd0);
        chk("rst_bit_count",  32'(bit_count),  32'd0);
        chk("rst_hunting",    32'(hunting),    32'd1);
        chk("rst_overrun",    32'(overrun),    32'd0);
        chk("rst_sync_err",   32'(sync_err),   32'd0);

        // 1: bits 1,0,1,0,0,1,0,1 -> 0xA5
        word_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_word(8'hA5, 1'b1);
        chk("t1_valid",     32'(word_valid), 32'd1);
        chk("t1_word",      32'(word_out),   32'hA5);
        chk("t1_bit_count", 32'(bit_count),  32'd0);
        chk("t1_sync_err",  32'(sync_err),   32'd0);
        chk("t1_hunting",   32'(hunting),    32'd0);
        step();
        chk("t1_consumed",  32'(word_valid), 32'd0);

        // 2: bits ignored while hunting, then aligned 0x3C
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        chk("t2_hunting",   32'(hunting),    32'd1);
        chk("t2_valid",     32'(word_valid), 32'd0);
        chk("t2_bit_count", 32'(bit_count),  32'd0);
        exp_q.push_back(8'h3C);
        send_word(8'h3C, 1'b1);
        chk("t2_word",      32'(word_out),   32'h3C);
        chk("t2_valid_hi",  32'(word_valid), 32'd1);
        step();

        // 3: second word dropped while the first is held
        word_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_word(8'h11, 1'b0);
        send_word(8'h22, 1'b0);
        chk("t3_word_held", 32'(word_out),   32'h11);
        chk("t3_valid",     32'(word_valid), 32'd1);
        chk("t3_overrun",   32'(overrun),    32'd1);
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t3_overrun_clr", 32'(overrun), 32'd0);
        word_ready = 1'b1;
        step();
        word_ready = 1'b0;
        chk("t3_drained",   32'(word_valid), 32'd0);

        // 4: consume in the same cycle the next word completes
        exp_q.push_back(8'h11);
        send_word(8'h11, 1'b0);
        w = 8'h22;
        for (int i = 0; i < int'(N) - 1; i++) send_bit(w[i], 1'b0);
        word_ready = 1'b1;
        exp_q.push_back(8'h22);
        send_bit(w[N-1], 1'b0);
        chk("t4_valid",     32'(word_valid), 32'd1);
        chk("t4_word",      32'(word_out),   32'h22);
        chk("t4_overrun",   32'(overrun),    32'd0);
        step();
        chk("t4_drained",   32'(word_valid), 32'd0);

        // 5: resync mid-word; clear_err on the same edge loses to the set
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        chk("t5_partial",   32'(bit_count),  32'd3);
        exp_q.push_back(8'h5A);
        w = 8'h5A;
        clear_err = 1'b1;
        send_bit(w[0], 1'b1);
        clear_err = 1'b0;
        chk("t5_sync_err",  32'(sync_err),   32'd1);
        chk("t5_restart",   32'(bit_count),  32'd1);
        for (int i = 1; i < int'(N); i++) send_bit(w[i], 1'b0);
        chk("t5_word",      32'(word_out),   32'h5A);
        chk("t5_valid",     32'(word_valid), 32'd1);
        step();
        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("t5_sync_clr",  32'(sync_err),   32'd0);

        // 6: reset mid-word with a word buffered and both flags set
        word_ready = 1'b0;
        send_word(8'h77, 1'b0);
        send_word(8'h66, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, (i == 2));
        chk("t6_pre_valid",   32'(word_valid), 32'd1);
        chk("t6_pre_overrun", 32'(overrun),    32'd1);
        chk("t6_pre_sync",    32'(sync_err),   32'd1);
        chk("t6_pre_count",   32'(bit_count),  32'd3);
        do_reset();
        chk("t6_valid",     32'(word_valid), 32'd0);
        chk("t6_bit_count", 32'(bit_count),  32'd0);
        chk("t6_hunting",   32'(hunting),    32'd1);
        chk("t6_overrun",   32'(overrun),    32'd0);
        chk("t6_sync_err",  32'(sync_err),   32'd0);
        chk("t6_word_out",  32'(word_out),   32'd0);

        step();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
